// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit ALU (add/sub/max) among NREQ requesters.
// Latency: gnt in cycle T, rsp_valid from T+2; one operation in flight, 3-cycle min issue interval.
// Backpressure: RESP holds rsp_* stable until rsp_ready; no grants are issued meanwhile.
module alu_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_sel,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_result,
    output logic              rsp_cout,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic           found;
    logic [3:0]     cap_a;
    logic [3:0]     cap_b;
    logic [2:0]     cap_sel;
    logic [IDW-1:0] cap_id;
    logic [4:0]     alu_sum;
    logic           alu_err;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= NREQ) j = j - NREQ;
        return IDW'(j);
    endfunction

    // Scan starts just past the last winner, so the last winner has lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[wrap_idx(last_grant, i)]) begin
                winner = wrap_idx(last_grant, i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        case (state)
            IDLE: begin
                if (found && !rst) begin
                    gnt[winner] = 1'b1;
                    state_nxt   = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract deliberately omits the +1 term to match the legacy subtractor.
    always_comb begin
        alu_sum = '0;
        alu_err = 1'b0;
        case (cap_sel)
            3'b000:  alu_sum = {1'b0, cap_a} + {1'b0, cap_b};
            3'b001:  alu_sum = {1'b0, cap_a} + {1'b0, ~cap_b};
            3'b010:  alu_sum = {1'b0, (cap_a > cap_b) ? cap_a : cap_b};
            default: alu_err = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            cap_a      <= '0;
            cap_b      <= '0;
            cap_sel    <= '0;
            cap_id     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                last_grant <= winner;
                cap_a      <= req_a[int'(winner)*4 +: 4];
                cap_b      <= req_b[int'(winner)*4 +: 4];
                cap_sel    <= req_sel[int'(winner)*3 +: 3];
                cap_id     <= winner;
            end
            if (state == EXEC) begin
                rsp_valid              <= 1'b1;
                rsp_id                 <= cap_id;
                {rsp_cout, rsp_result} <= alu_sum;
                rsp_err                <= alu_err;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Round-robin scheduler that shares one 4-bit ALU datapath (add / subtract / max-compare) among NREQ requesters. It arbitrates pending requests and captures the winner's operands and select code. It then executes one operation and returns a tagged result through a valid/ready response port. Only one operation is in flight at a time. The block sits between requesting control units and the ALU, and owns the ALU's sequencing.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must equal ceil(log2(NREQ))

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester request; held until the matching gnt bit is seen
req_a  in  4*NREQ  operand A, packed; requester i uses bits [4i+3:4i]
req_b  in  4*NREQ  operand B, packed, same layout as req_a
req_sel  in  3*NREQ  operation select, packed; requester i uses bits [3i+2:3i]
gnt  out  NREQ  one-hot grant, one-cycle pulse; operands are captured on that edge
busy  out  1  high when state != IDLE
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_id  out  IDW  index of the requester that issued the operation
rsp_result  out  4  ALU result
rsp_cout  out  1  ALU carry / flag bit
rsp_err  out  1  unsupported select code

Behaviour:
- State machine: IDLE, EXEC, RESP.
- Reset: state=IDLE; last_grant=NREQ-1, so requester 0 has first priority.
- Reset values: gnt=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, rsp_err=0, busy=0.
- Asserting rst in any state abandons the operation in flight. No response is produced for it.
- IDLE, arbitration:
  - If any req bit is set, the winner is the first set bit scanning from (last_grant+1) mod NREQ upward, with wrap-around.
  - gnt[winner] is driven combinationally in IDLE only.
  - On that clock edge: capture the winner's A, B, sel and ID; set last_grant=winner; go to EXEC.
- IDLE with req=0: stay in IDLE; gnt=0.
- A req bit dropped before it is granted has no effect. The requester drops req after seeing gnt.
- EXEC, one cycle: compute from the captured operands and register the result into the rsp_* outputs. On the next edge set rsp_valid=1 and go to RESP.
- Arithmetic, {cout, result} is a 5-bit value:
  - sel=000 (add): A + B, zero-extended to 5 bits.
  - sel=001 (subtract): A + ~B, 5-bit, no +1 term. This matches the existing subtractor; consumers correct for it if needed.
  - sel=010 (max): result = (A > B) ? A : B, unsigned compare; cout=0.
  - sel=011..111: result=0, cout=0, rsp_err=1.
  - rsp_err=0 for all supported codes.
- RESP:
  - rsp_valid is held high; rsp_id, rsp_result, rsp_cout and rsp_err are held stable.
  - No grant is issued while in RESP.
  - When rsp_ready=1 on an edge: rsp_valid=0 on that edge, go to IDLE.
  - The next grant can appear in the IDLE cycle that follows.
- Latency:
  - gnt in cycle T, rsp_valid from cycle T+2.
  - Minimum issue interval is 3 cycles when rsp_ready is held high.
- rsp_ready while rsp_valid=0 is ignored.
- Fairness: with all requesters pending continuously, the grant order is strictly cyclic and no requester waits more than NREQ grants.

Test Plan:
- Add, single requester: reset, then req[0]=1, A=7, B=9, sel=000, rsp_ready=1. Required: gnt=0001 in cycle 0; rsp_valid=1 in cycle 2 with rsp_result=0, rsp_cout=1, rsp_id=0, rsp_err=0; IDLE in cycle 3.
- Subtract and max, requester 2:
  - A=5, B=3, sel=001 -> result=1, cout=1 (5+12=17).
  - A=3, B=12, sel=010 -> result=12, cout=0.
  - A=B=6, sel=010 -> result=6.
  - In all three cases rsp_id=2.
- Round-robin: req=1111 held continuously, rsp_ready=1. Required: grant sequence 0,1,2,3,0,1, one grant every 3 cycles. Then drop req[1] -> sequence skips index 1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, with req[3] pending. Required: rsp_* outputs stable, gnt=0, busy=1 throughout. rsp_ready=1 -> IDLE next, then gnt[3].
- Illegal select: sel=101, A=15, B=15. Required: rsp_result=0, rsp_cout=0, rsp_err=1.
- Reset mid-operation: assert rst asynchronously during EXEC. Required: rsp_valid stays 0 and all outputs go to 0 immediately. After release, with req=1010, gnt[1] comes first.
